systolic_tile_loader: RTL

Upstream feeder for `systolic_control`. It ingests matrix A and matrix B elements as two independent valid/ready streams and assembles each into an N-element staging vector. When both vectors are complete and the array is idle, it launches a tile: parallel `load` pulse, then a `read_en` window long enough to drain every staggered injection FIFO, then a wait for the array's `complete_flag`. Staging is double-buffered, so the next tile fills while the current one streams.

---
 rtl/systolic_pkg.sv | 20 ++
 rtl/vec_stager.sv | 69 ++++++
 rtl/systolic_tile_loader.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array feeder.
// Holds the default array geometry (N lanes, DW-bit elements, K FIFO
// entries per tile), the element type and the tile loader state encoding.
package systolic_pkg;

   localparam int N  = 32;
   localparam int DW = 16;
   localparam int K  = 32;

   typedef logic [DW-1:0] elem_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_STREAM,
      ST_WAIT_DONE,
      ST_DONE
   } loader_state_e;

endpackage

// File: rtl/vec_stager.sv
// One N-element staging buffer fed by a valid/ready stream.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   in_valid/in_ready   element handshake; in_ready is combinational
//   in_data             element written at the current index
//   clear               drops the full flag once the vector has been launched
//   full                all N elements staged, no further elements accepted
//   stage[0:N-1]        staged vector contents
module vec_stager #(
   parameter int N  = systolic_pkg::N,
   parameter int DW = systolic_pkg::DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   input  logic          clear,
   output logic          full,
   output logic [DW-1:0] stage [0:N-1]
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

   logic [IW-1:0] idx_q, idx_d;
   logic          full_q, full_d;
   logic [DW-1:0] stage_q [0:N-1];
   logic [DW-1:0] stage_d [0:N-1];
   logic          accept;

   assign in_ready = !full_q && !rst;
   assign accept   = in_valid && in_ready;

   always_comb begin
      idx_d   = idx_q;
      full_d  = full_q;
      stage_d = stage_q;
      // clear only arrives while full, when nothing can be accepted
      if (clear) begin
         full_d = 1'b0;
      end
      if (accept) begin
         stage_d[idx_q] = in_data;
         if (idx_q == IDX_LAST) begin
            idx_d  = '0;
            full_d = 1'b1;
         end else begin
            idx_d = idx_q + IW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q   <= '0;
         full_q  <= 1'b0;
         stage_q <= '{default: '0};
      end else begin
         idx_q   <= idx_d;
         full_q  <= full_d;
         stage_q <= stage_d;
      end
   end

   assign full  = full_q;
   assign stage = stage_q;

endmodule

// File: rtl/systolic_tile_loader.sv
// Tile launcher in front of systolic_control.
// Stages A and B vectors from two independent streams (double-buffered),
// then per tile: one-cycle load strobe, K+N-1 cycles of read_en to drain
// every staggered FIFO, wait for complete_flag, one-cycle tile_done.
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   a_valid/a_ready/a_data        A element stream
//   b_valid/b_ready/b_data        B element stream
//   A_in/B_in[0:N-1]              launched vectors, change only on launch
//   load, read_en                 FIFO parallel-load strobe and read enable
//   complete_flag                 array finished the current tile
//   busy, tile_done, tile_count   status
//
// state        | meaning
// ST_IDLE      | waiting for both staging vectors to be full
// ST_LOAD      | load strobe high, launched vectors presented
// ST_STREAM    | read_en high for K+N-1 cycles
// ST_WAIT_DONE | waiting for complete_flag
// ST_DONE      | tile_done pulse, tile_count already incremented
module systolic_tile_loader
   import systolic_pkg::*;
#(
   parameter int N  = systolic_pkg::N,
   parameter int DW = systolic_pkg::DW,
   parameter int K  = systolic_pkg::K
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a_valid,
   output logic          a_ready,
   input  logic [DW-1:0] a_data,
   input  logic          b_valid,
   output logic          b_ready,
   input  logic [DW-1:0] b_data,
   output logic [DW-1:0] A_in [0:N-1],
   output logic [DW-1:0] B_in [0:N-1],
   output logic          load,
   output logic          read_en,
   input  logic          complete_flag,
   output logic          busy,
   output logic          tile_done,
   output logic [15:0]   tile_count
);

   localparam int CW = $clog2(K + N);
   localparam logic [CW-1:0] STREAM_LAST = CW'(K + N - 2);

   loader_state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] a_in_q [0:N-1];
   logic [DW-1:0] a_in_d [0:N-1];
   logic [DW-1:0] b_in_q [0:N-1];
   logic [DW-1:0] b_in_d [0:N-1];
   logic          load_q, load_d;
   logic          read_en_q, read_en_d;
   logic          busy_q, busy_d;
   logic          tile_done_q, tile_done_d;
   logic [15:0]   tile_count_q, tile_count_d;

   logic [DW-1:0] a_stage [0:N-1];
   logic [DW-1:0] b_stage [0:N-1];
   logic          a_full, b_full;
   logic          launch;

   vec_stager #(.N(N), .DW(DW)) u_a_stager (
      .clk      (clk),
      .rst      (rst),
      .in_valid (a_valid),
      .in_ready (a_ready),
      .in_data  (a_data),
      .clear    (launch),
      .full     (a_full),
      .stage    (a_stage)
   );

   vec_stager #(.N(N), .DW(DW)) u_b_stager (
      .clk      (clk),
      .rst      (rst),
      .in_valid (b_valid),
      .in_ready (b_ready),
      .in_data  (b_data),
      .clear    (launch),
      .full     (b_full),
      .stage    (b_stage)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      a_in_d       = a_in_q;
      b_in_d       = b_in_q;
      tile_count_d = tile_count_q;
      launch       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (a_full && b_full) begin
               launch  = 1'b1;
               state_d = ST_LOAD;
               a_in_d  = a_stage;
               b_in_d  = b_stage;
            end
         end
         ST_LOAD: begin
            state_d = ST_STREAM;
            cnt_d   = '0;
         end
         ST_STREAM: begin
            // covers K pops plus the deepest stagger of N-1 cycles
            if (cnt_q == STREAM_LAST) begin
               state_d = ST_WAIT_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_WAIT_DONE: begin
            if (complete_flag) begin
               state_d      = ST_DONE;
               tile_count_d = tile_count_q + 16'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // outputs registered from the next state so they line up with it
      load_d      = (state_d == ST_LOAD);
      read_en_d   = (state_d == ST_STREAM);
      tile_done_d = (state_d == ST_DONE);
      busy_d      = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         a_in_q       <= '{default: '0};
         b_in_q       <= '{default: '0};
         load_q       <= 1'b0;
         read_en_q    <= 1'b0;
         busy_q       <= 1'b0;
         tile_done_q  <= 1'b0;
         tile_count_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         a_in_q       <= a_in_d;
         b_in_q       <= b_in_d;
         load_q       <= load_d;
         read_en_q    <= read_en_d;
         busy_q       <= busy_d;
         tile_done_q  <= tile_done_d;
         tile_count_q <= tile_count_d;
      end
   end

   assign A_in       = a_in_q;
   assign B_in       = b_in_q;
   assign load       = load_q;
   assign read_en    = read_en_q;
   assign busy       = busy_q;
   assign tile_done  = tile_done_q;
   assign tile_count = tile_count_q;

endmodule
